// File: rtl/traffic_junction_ctrl.sv
// traffic_junction_ctrl: two-road junction sequencer (NS main, EW side, pedestrian walk).
// Moore lamp decode from the state register; per-state dwell timer; latched
// EW and pedestrian demand with all-red clearance between conflicting greens.
module traffic_junction_ctrl #(
  parameter int GREEN_CYCLES      = 8,
  parameter int ORANGE_CYCLES     = 3,
  parameter int RED_ORANGE_CYCLES = 2,
  parameter int ALLRED_CYCLES     = 2,
  parameter int WALK_CYCLES       = 6,
  parameter int TW                = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ew_req,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_orange,
  output logic ns_green,
  output logic ew_red,
  output logic ew_orange,
  output logic ew_green,
  output logic walk,
  output logic ped_ack,
  output logic ped_waiting
);

  typedef enum logic [3:0] {
    ALLRED_A, NS_RA, NS_G, NS_O, ALLRED_B, EW_RA, EW_G, EW_O, WALK
  } state_t;

  // Timer load values are duration-1 so a state lasts exactly its duration.
  localparam logic [TW-1:0] T_G  = TW'(GREEN_CYCLES - 1);
  localparam logic [TW-1:0] T_O  = TW'(ORANGE_CYCLES - 1);
  localparam logic [TW-1:0] T_RA = TW'(RED_ORANGE_CYCLES - 1);
  localparam logic [TW-1:0] T_AR = TW'(ALLRED_CYCLES - 1);
  localparam logic [TW-1:0] T_WK = TW'(WALK_CYCLES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, load_val;
  logic          ew_pend_q, ped_pend_q, from_ns_q, ack_q;
  logic          tz, enter;

  assign tz    = (timer_q == '0);
  assign enter = (state_d != state_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ALLRED_A;
    else       state_q <= state_d;
  end

  // Next-state: advance on timer expiry, NS green holds until demand exists.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALLRED_A: if (tz) state_d = NS_RA;
      NS_RA:    if (tz) state_d = NS_G;
      NS_G:     if (tz && (ew_pend_q || ped_pend_q)) state_d = NS_O;
      NS_O:     if (tz) state_d = ped_pend_q ? WALK : ALLRED_B;
      ALLRED_B: if (tz) state_d = EW_RA;
      EW_RA:    if (tz) state_d = EW_G;
      EW_G:     if (tz) state_d = EW_O;
      EW_O:     if (tz) state_d = ped_pend_q ? WALK : ALLRED_A;
      WALK:     if (tz) state_d = (ew_pend_q && from_ns_q) ? ALLRED_B : ALLRED_A;
      default:  state_d = ALLRED_A;
    endcase
  end

  // Dwell length of the state being entered.
  always_comb begin
    load_val = T_AR;
    case (state_d)
      NS_RA, EW_RA: load_val = T_RA;
      NS_G,  EW_G:  load_val = T_G;
      NS_O,  EW_O:  load_val = T_O;
      WALK:         load_val = T_WK;
      default:      load_val = T_AR;
    endcase
  end

  // Timer, demand latches, walk origin and the first-WALK-cycle flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= T_AR;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      from_ns_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      if (enter)    timer_q <= load_val;
      else if (!tz) timer_q <= timer_q - TW'(1);

      // Clear on entry to EW green wins over a same-cycle request.
      if (enter && state_d == EW_G) ew_pend_q <= 1'b0;
      else if (ew_req)              ew_pend_q <= 1'b1;

      // Button presses during WALK are already being served.
      if (enter && state_d == WALK)          ped_pend_q <= 1'b0;
      else if (ped_req && state_q != WALK)   ped_pend_q <= 1'b1;

      if (enter && state_d == WALK) from_ns_q <= (state_q == NS_O);

      ack_q <= enter && (state_d == WALK);
    end
  end

  // Lamp decode: a road not in an active phase shows red.
  always_comb begin
    ns_red = 1'b1; ns_orange = 1'b0; ns_green = 1'b0;
    ew_red = 1'b1; ew_orange = 1'b0; ew_green = 1'b0;
    walk   = 1'b0;
    case (state_q)
      NS_RA: ns_orange = 1'b1;
      NS_G:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_O:  begin ns_red = 1'b0; ns_orange = 1'b1; end
      EW_RA: ew_orange = 1'b1;
      EW_G:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_O:  begin ew_red = 1'b0; ew_orange = 1'b1; end
      WALK:  walk = 1'b1;
      default: ;
    endcase
    ped_ack     = ack_q;
    ped_waiting = ped_pend_q;
  end

endmodule
